// File: rtl/elevator_n.sv
// SCAN-policy elevator controller for FLOORS floors with latched hall/car calls
// and an automatic door dwell timeout. All outputs are registered Moore outputs.
module elevator_n #(
    parameter int FLOORS = 4,
    parameter int FSW    = $clog2(FLOORS + 1),
    parameter int DWELL  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] UP,
    input  logic [FLOORS-1:0] DOWN,
    input  logic [FLOORS-1:0] FLOOR,
    input  logic              DC,
    input  logic [FSW-1:0]    FS,
    output logic              door,
    output logic [1:0]        direction,
    output logic [FSW-1:0]    cur_floor,
    output logic [FLOORS-1:0] pending
);

    localparam int TW = $clog2(DWELL);
    localparam logic [FLOORS-1:0] TOP_BIT = {1'b1, {(FLOORS-1){1'b0}}};
    localparam logic [FLOORS-1:0] BOT_BIT = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    typedef enum logic [1:0] {S_CLOSING, S_OPENED, S_UP, S_DOWN} state_t;

    state_t            state_q, state_d;
    logic [FSW-1:0]    cur_floor_q, cur_floor_d;
    logic [FLOORS-1:0] up_q, up_d, dn_q, dn_d, car_q, car_d;
    logic              sweep_up_q, sweep_up_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              door_q, door_d;
    logic [1:0]        dir_q, dir_d;

    logic [FLOORS-1:0] up_in, dn_in, car_in, eff, cur_oh, fs_oh;
    logic              any_above, any_below, fs_above, fs_below;
    logic              fs_up_hit, fs_dn_hit;

    function automatic logic [FLOORS-1:0] floor_oh(input logic [FSW-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (int'(f) == i + 1);
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] above_mask(input logic [FSW-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i + 1 > int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] below_mask(input logic [FSW-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i + 1 < int'(f));
        return m;
    endfunction

    always_comb begin
        // Top-floor up and bottom-floor down buttons have no meaning.
        up_in     = UP & ~TOP_BIT;
        dn_in     = DOWN & ~BOT_BIT;
        car_in    = FLOOR;
        cur_oh    = floor_oh(cur_floor_q);
        fs_oh     = floor_oh(FS);
        eff       = up_q | dn_q | car_q | up_in | dn_in | car_in;
        any_above = |(eff & above_mask(cur_floor_q));
        any_below = |(eff & below_mask(cur_floor_q));
        fs_above  = |(eff & above_mask(FS));
        fs_below  = |(eff & below_mask(FS));
        fs_up_hit = (int'(FS) == int'(cur_floor_q) + 1);
        fs_dn_hit = (int'(FS) >= 1) && (int'(FS) + 1 == int'(cur_floor_q));

        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        sweep_up_d  = sweep_up_q;
        timer_d     = timer_q;
        up_d        = up_q | up_in;
        dn_d        = dn_q | dn_in;
        car_d       = car_q | car_in;

        case (state_q)
            S_CLOSING: begin
                if (|(eff & cur_oh)) begin
                    state_d = S_OPENED;
                    up_d    = up_d & ~cur_oh;
                    dn_d    = dn_d & ~cur_oh;
                    car_d   = car_d & ~cur_oh;
                    timer_d = '0;
                end else if (DC && (any_above || any_below)) begin
                    if (sweep_up_q && any_above) begin
                        state_d = S_UP;
                    end else if (any_below) begin
                        state_d    = S_DOWN;
                        sweep_up_d = 1'b0;
                    end else begin
                        state_d    = S_UP;
                        sweep_up_d = 1'b1;
                    end
                end
            end
            S_OPENED: begin
                // Calls for the open floor are already served; they only hold the door.
                up_d  = up_q | (up_in & ~cur_oh);
                dn_d  = dn_q | (dn_in & ~cur_oh);
                car_d = car_q | (car_in & ~cur_oh);
                if (|(car_in & ~cur_oh)) begin
                    state_d = S_CLOSING;
                    timer_d = '0;
                end else if (|((up_in | dn_in | car_in) & cur_oh)) begin
                    timer_d = '0;
                end else if (timer_q == TW'(DWELL - 1)) begin
                    state_d = S_CLOSING;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_UP: begin
                if (fs_up_hit) begin
                    cur_floor_d = FS;
                    if (|(fs_oh & (car_d | up_d)) || !fs_above) begin
                        car_d   = car_d & ~fs_oh;
                        up_d    = up_d & ~fs_oh;
                        state_d = S_OPENED;
                        timer_d = '0;
                        if (!fs_above) begin
                            dn_d       = dn_d & ~fs_oh;
                            sweep_up_d = 1'b0;
                        end
                    end
                end
            end
            S_DOWN: begin
                if (fs_dn_hit) begin
                    cur_floor_d = FS;
                    if (|(fs_oh & (car_d | dn_d)) || !fs_below) begin
                        car_d   = car_d & ~fs_oh;
                        dn_d    = dn_d & ~fs_oh;
                        state_d = S_OPENED;
                        timer_d = '0;
                        if (!fs_below) begin
                            up_d       = up_d & ~fs_oh;
                            sweep_up_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_CLOSING;
        endcase

        door_d = (state_d != S_OPENED);
        case (state_d)
            S_UP:    dir_d = DIR_UP;
            S_DOWN:  dir_d = DIR_DN;
            default: dir_d = DIR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLOSING;
            cur_floor_q <= FSW'(1);
            up_q        <= '0;
            dn_q        <= '0;
            car_q       <= '0;
            sweep_up_q  <= 1'b1;
            timer_q     <= '0;
            door_q      <= 1'b1;
            dir_q       <= DIR_IDLE;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            car_q       <= car_d;
            sweep_up_q  <= sweep_up_d;
            timer_q     <= timer_d;
            door_q      <= door_d;
            dir_q       <= dir_d;
        end
    end

    assign door      = door_q;
    assign direction = dir_q;
    assign cur_floor = cur_floor_q;
    assign pending   = up_q | dn_q | car_q;

endmodule

// File: doc/elevator_n.md
Name: elevator_n

Overview:
Parametrised successor to the three-floor elevator controller. It serves FLOORS floors using a SCAN policy: the car keeps its travel direction while requests remain ahead of it. Hall calls and car calls are latched into pending registers, and the door has an automatic dwell timeout. The block instantiates in `top` like the existing controller and drives the same door/direction actuator encoding.

Parameters:
FLOORS, 4, number of floors (2..15); floors are numbered 1..FLOORS.
FSW, $clog2(FLOORS+1), width of floor-sensor and floor-index fields.
DWELL, 8, number of cycles the door stays open before auto-close (>=2).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
UP  in  FLOORS  hall up buttons; bit k-1 is floor k; bit FLOORS-1 is ignored.
DOWN  in  FLOORS  hall down buttons; bit 0 is ignored.
FLOOR  in  FLOORS  car buttons; bit k-1 requests floor k.
DC  in  1  door-closed sensor (1 = fully closed).
FS  in  FSW  floor sensor: 0 = between floors, k = level with floor k.
door  out  1  door command: 1 = close/keep closed, 0 = open.
direction  out  2  00 idle, 01 up, 10 down, 11 never driven.
cur_floor  out  FSW  last floor reached, 1..FLOORS.
pending  out  FLOORS  per-floor OR of latched up, down and car requests.

Behaviour:
- One clock domain. Reset is synchronous and active-high, named clk/rst. All outputs are registered Moore outputs.
- Reset (including mid-travel): state CLOSING, cur_floor=1, all pending cleared, sweep=up, timer=0, door=1, direction=00.
- Request latching: each input bit set in a cycle sets its pending bit at that edge. Decisions use eff = pending | inputs, so the response appears at the edge that samples the press. Buttons need not be held.
- Requests for cur_floor arriving while in OPENED are not latched; they restart the dwell timer.
- Internal sweep register (up/down) holds the current SCAN direction.
- "above" means any eff bit for floors > cur_floor; "below" means floors < cur_floor.

States:
- CLOSING (door=1, dir=00):
  - Any eff request at cur_floor -> OPENED; clear that floor's car call and hall calls; timer=0.
  - Else if DC=1 and above/below exist: if sweep=up and above -> UP; else if below -> DOWN, sweep=down; else -> UP, sweep=up.
  - Else stay in CLOSING (idle).
- OPENED (door=0, dir=00):
  - Timer increments each cycle.
  - Timer=DWELL-1 -> CLOSING.
  - A new FLOOR press for a floor other than cur_floor -> CLOSING at that edge, latched; this is the early close.
- UP (door=1, dir=01):
  - FS=cur_floor+1 updates cur_floor.
  - Stop -> OPENED when that floor has a car call, an up call, or nothing above it.
  - On stop, clear the car call and up call. If nothing is above, also clear the down call and set sweep=down.
  - Otherwise keep moving.
- DOWN (door=1, dir=10): mirror of UP, using down calls and floors below.
- FS handling while moving: FS=0 and any FS not equal to cur_floor±1 in the travel direction are ignored. FS is not sampled in CLOSING or OPENED.
- Boundaries:
  - UP can never pass FLOORS, because the top floor always stops since nothing is above it.
  - DOWN likewise always stops at floor 1.
- Simultaneous events:
  - rst has priority over everything.
  - A clear and a new press of the same bit on the same edge: the press wins (bit stays set), except at cur_floor in OPENED.
- pending reflects the registered request bits only, not the raw inputs.

Test Plan:
1. FLOORS=4, DWELL=8. Reset 2 cycles -> state CLOSING, door=1, direction=00, cur_floor=1, pending=0000.
2. Pulse UP[0] for 1 cycle -> door=0 at the next edge. Hold 8 cycles -> door=1. Hold DC=1 with no request -> direction stays 00.
3. From OPENED at floor 1, press FLOOR[3] -> door=1 next edge, pending=1000. With DC=1 -> direction=01. Drive FS=2 then FS=3 -> no stop, cur_floor=3. Drive FS=4 -> door=0, direction=00, cur_floor=4, pending=0000.
4. Car at 1 moving up to 4 with DOWN[1] pending: pass floor 2 without stopping. At 4, pending=0010 remains. After dwell and DC=1 -> direction=10, sweep reverses, stop at FS=2.
5. Moving up (direction=01), drive FS=0, then FS=3 while cur_floor=1 -> both ignored, cur_floor stays 1, direction stays 01.
6. Assert rst during UP travel with pending=1010 -> next edge: door=1, direction=00, cur_floor=1, pending=0000.
